// File: rtl/cpu_mem_responder_if.sv
// Bundle of CPU-side strobes and responder outputs for cpu_mem_responder.
// Latency: none (wires only).
// Backpressure: none; stall and overrun tell the controller that the responder is busy.
// Ports: master = CPU controller/loader side, slave = memory responder side.
interface cpu_mem_responder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              ins_en;
    logic [ADDR_W-1:0] ins_addr;
    logic [DATA_W-1:0] ins_data;
    logic              ins_valid;
    logic              da_en;
    logic              da_we;
    logic [ADDR_W-1:0] da_addr;
    logic [DATA_W-1:0] da_wdata;
    logic [DATA_W-1:0] da_rdata;
    logic              da_valid;
    logic              stall;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              overrun;

    modport master (
        output ins_en, ins_addr, da_en, da_we, da_addr, da_wdata,
               ld_en, ld_addr, ld_data,
        input  ins_data, ins_valid, da_rdata, da_valid, stall, overrun
    );

    modport slave (
        input  ins_en, ins_addr, da_en, da_we, da_addr, da_wdata,
               ld_en, ld_addr, ld_data,
        output ins_data, ins_valid, da_rdata, da_valid, stall, overrun
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Single-port memory responder serving instruction fetches, data reads/writes and a loader port.
// Latency: strobe-to-valid WAIT_CYCLES+2 cycles for an isolated request; loader writes take effect at the strobe edge.
// Backpressure: one pending slot per port; stall flags busy, overflowing requests are dropped and set sticky overrun.
// Ports: clk, rst (async, active-high), bus (slave modport: ins_*, da_*, ld_*, stall, overrun).
module cpu_mem_responder #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_mem_responder_if.slave    bus
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [2:0] CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              act_da_q, act_we_q;
    logic [ADDR_W-1:0] act_addr_q;
    logic [DATA_W-1:0] act_wdata_q;

    logic              pins_vld_q, pins_vld_d;
    logic [ADDR_W-1:0] pins_addr_q;
    logic              pda_vld_q, pda_vld_d;
    logic              pda_we_q;
    logic [ADDR_W-1:0] pda_addr_q;
    logic [DATA_W-1:0] pda_wdata_q;

    logic [DATA_W-1:0] ins_data_q, da_rdata_q;
    logic              ins_valid_q, da_valid_q, stall_q, stall_d, overrun_q;

    logic idle, ld_acc, sel_pins, sel_lins, sel_pda, sel_lda, acc;
    logic ins_push, ins_drop, da_push, da_drop;
    logic mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    always_comb begin
        idle     = (state_q == S_IDLE);
        // Loader only gets in when nothing is queued, so it never reorders CPU traffic.
        ld_acc   = idle && bus.ld_en && !pins_vld_q && !pda_vld_q;
        sel_pins = idle && !ld_acc && pins_vld_q;
        sel_lins = idle && !ld_acc && !pins_vld_q && bus.ins_en;
        sel_pda  = idle && !ld_acc && !pins_vld_q && !bus.ins_en && pda_vld_q;
        sel_lda  = idle && !ld_acc && !pins_vld_q && !bus.ins_en && !pda_vld_q && bus.da_en;
        acc      = sel_pins || sel_lins || sel_pda || sel_lda;

        // A live strobe not served this edge is parked; a slot being drained this edge can take it.
        ins_push = bus.ins_en && !sel_lins;
        ins_drop = ins_push && pins_vld_q && !sel_pins;
        da_push  = bus.da_en && !sel_lda;
        da_drop  = da_push && pda_vld_q && !sel_pda;

        pins_vld_d = (ins_push && !ins_drop) ? 1'b1 : (sel_pins ? 1'b0 : pins_vld_q);
        pda_vld_d  = (da_push && !da_drop)   ? 1'b1 : (sel_pda  ? 1'b0 : pda_vld_q);

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (acc) begin
                state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                cnt_d   = CNT_INIT;
            end
            S_WAIT: if (cnt_q == 3'd0) state_d = S_RESP;
                    else               cnt_d   = cnt_q - 3'd1;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Stall also covers the cycle the registered response is visible.
        stall_d = (state_d != S_IDLE) || (state_q != S_IDLE) || pins_vld_d || pda_vld_d;

        // An in-flight write is dropped if reset is asserted before its commit edge.
        mem_we_d    = ld_acc || (!rst && state_q == S_RESP && act_da_q && act_we_q);
        mem_waddr_d = ld_acc ? bus.ld_addr : act_addr_q;
        mem_wdata_d = ld_acc ? bus.ld_data : act_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) mem[mem_waddr_d] <= mem_wdata_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            act_da_q    <= 1'b0;
            act_we_q    <= 1'b0;
            act_addr_q  <= '0;
            act_wdata_q <= '0;
            pins_vld_q  <= 1'b0;
            pins_addr_q <= '0;
            pda_vld_q   <= 1'b0;
            pda_we_q    <= 1'b0;
            pda_addr_q  <= '0;
            pda_wdata_q <= '0;
            ins_data_q  <= '0;
            da_rdata_q  <= '0;
            ins_valid_q <= 1'b0;
            da_valid_q  <= 1'b0;
            stall_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pins_vld_q <= pins_vld_d;
            pda_vld_q  <= pda_vld_d;
            stall_q    <= stall_d;
            if (ins_drop || da_drop) overrun_q <= 1'b1;

            if (ins_push && !ins_drop) pins_addr_q <= bus.ins_addr;
            if (da_push && !da_drop) begin
                pda_we_q    <= bus.da_we;
                pda_addr_q  <= bus.da_addr;
                pda_wdata_q <= bus.da_wdata;
            end

            if (acc) begin
                act_da_q    <= sel_pda || sel_lda;
                act_we_q    <= sel_pda ? pda_we_q : (sel_lda ? bus.da_we : 1'b0);
                act_addr_q  <= sel_pins ? pins_addr_q :
                               sel_lins ? bus.ins_addr :
                               sel_pda  ? pda_addr_q : bus.da_addr;
                act_wdata_q <= sel_pda ? pda_wdata_q : bus.da_wdata;
            end

            ins_valid_q <= 1'b0;
            da_valid_q  <= 1'b0;
            if (state_q == S_RESP) begin
                if (!act_da_q) begin
                    ins_data_q  <= mem[act_addr_q];
                    ins_valid_q <= 1'b1;
                end else begin
                    if (!act_we_q) da_rdata_q <= mem[act_addr_q];
                    da_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ins_data  = ins_data_q;
    assign bus.ins_valid = ins_valid_q;
    assign bus.da_rdata  = da_rdata_q;
    assign bus.da_valid  = da_valid_q;
    assign bus.stall     = stall_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: WAIT_CYCLES=1 instance (a) and WAIT_CYCLES=0 instance (b).
// Cycle c is the interval after the c-th rising edge; strobes are driven 1ns after an edge.
// Expected responses carry the cycle in which the valid pulse must be seen.
module tb_cpu_mem_responder;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_mem_responder_if #(.ADDR_W(5), .DATA_W(8)) a ();
    cpu_mem_responder_if #(.ADDR_W(5), .DATA_W(8)) b ();

    cpu_mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(1)) dut_a (.clk(clk), .rst(rst_a), .bus(a));
    cpu_mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(0)) dut_b (.clk(clk), .rst(rst_b), .bus(b));

    typedef struct {
        logic       wr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t qa_ins[$];
    exp_t qa_da[$];
    exp_t qb_ins[$];
    exp_t ea, eb, ec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: unexpected valid pulse in cycle %0d", name, cyc);
    endtask

    // Monitors: compare whenever a valid pulse is presented.
    always @(negedge clk) begin
        if (a.ins_valid === 1'b1) begin
            if (qa_ins.size() == 0) unexpected("a_ins");
            else begin
                ea = qa_ins.pop_front();
                chk("a_ins_cycle", cyc, ea.cyc);
                chk("a_ins_data", a.ins_data, ea.data);
            end
        end
        if (a.da_valid === 1'b1) begin
            if (qa_da.size() == 0) unexpected("a_da");
            else begin
                eb = qa_da.pop_front();
                chk("a_da_cycle", cyc, eb.cyc);
                if (!eb.wr) chk("a_da_rdata", a.da_rdata, eb.data);
            end
        end
        if (b.ins_valid === 1'b1) begin
            if (qb_ins.size() == 0) unexpected("b_ins");
            else begin
                ec = qb_ins.pop_front();
                chk("b_ins_cycle", cyc, ec.cyc);
                chk("b_ins_data", b.ins_data, ec.data);
            end
        end
        if (b.da_valid === 1'b1) unexpected("b_da");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int port, input logic wr, input logic [7:0] d, input int c);
        exp_t e;
        e.wr = wr; e.data = d; e.cyc = c;
        if (port == 0) qa_ins.push_back(e);
        else if (port == 1) qa_da.push_back(e);
        else qb_ins.push_back(e);
    endtask

    task automatic check_a_zero(input string tag);
        chk({tag, "_ins_data"}, a.ins_data, 0);
        chk({tag, "_da_rdata"}, a.da_rdata, 0);
        chk({tag, "_ins_valid"}, a.ins_valid, 0);
        chk({tag, "_da_valid"}, a.da_valid, 0);
        chk({tag, "_stall"}, a.stall, 0);
        chk({tag, "_overrun"}, a.overrun, 0);
    endtask

    initial begin
        a.ins_en = 0; a.ins_addr = 0; a.da_en = 0; a.da_we = 0; a.da_addr = 0; a.da_wdata = 0;
        a.ld_en = 0; a.ld_addr = 0; a.ld_data = 0;
        b.ins_en = 0; b.ins_addr = 0; b.da_en = 0; b.da_we = 0; b.da_addr = 0; b.da_wdata = 0;
        b.ld_en = 0; b.ld_addr = 0; b.ld_data = 0;

        goto(3);
        check_a_zero("reset");
        rst_a = 0; rst_b = 0;

        // Preload both arrays.
        a.ld_en = 1; a.ld_addr = 0; a.ld_data = 8'hA5;
        b.ld_en = 1; b.ld_addr = 4; b.ld_data = 8'h44;
        tick();
        a.ld_addr = 1; a.ld_data = 8'h3C;
        b.ld_addr = 5; b.ld_data = 8'h55;
        tick();
        a.ld_addr = 2; a.ld_data = 8'h5A;
        b.ld_en = 0;
        tick();
        a.ld_addr = 3; a.ld_data = 8'hC3;
        tick();
        a.ld_addr = 7; a.ld_data = 8'h11;
        tick();
        a.ld_en = 0;

        // Isolated fetch, strobe in cycle 10, valid in cycle 13; stall high 11..13.
        goto(10);
        chk("stall_c10", a.stall, 0);
        a.ins_en = 1; a.ins_addr = 0; push(0, 0, 8'hA5, 13);
        tick(); a.ins_en = 0;
        chk("stall_c11", a.stall, 1);
        tick(); chk("stall_c12", a.stall, 1);
        tick(); chk("stall_c13", a.stall, 1);
        tick(); chk("stall_c14", a.stall, 0);

        // Data write then read-back of the same address.
        goto(16);
        a.da_en = 1; a.da_we = 1; a.da_addr = 5; a.da_wdata = 8'h77; push(1, 1, 8'h00, 19);
        tick(); a.da_en = 0; a.da_we = 0;
        goto(22);
        a.da_en = 1; a.da_addr = 5; push(1, 0, 8'h77, 25);
        tick(); a.da_en = 0;

        // Simultaneous fetch and data read: fetch first, data W+2 cycles later.
        goto(28);
        a.ins_en = 1; a.ins_addr = 1; push(0, 0, 8'h3C, 31);
        a.da_en = 1; a.da_addr = 0; push(1, 0, 8'hA5, 34);
        tick(); a.ins_en = 0; a.da_en = 0;
        goto(36);
        chk("overrun_after_simul", a.overrun, 0);

        // Busy: addr 2 parks in the slot, addr 3 overflows and is dropped.
        goto(38);
        a.ins_en = 1; a.ins_addr = 0; push(0, 0, 8'hA5, 41);
        tick(); a.ins_en = 0;
        a.da_en = 1; a.da_addr = 2; push(1, 0, 8'h5A, 44);
        tick(); a.da_addr = 3;
        tick(); a.da_en = 0;
        chk("overrun_set", a.overrun, 1);
        goto(48);
        chk("overrun_sticky", a.overrun, 1);

        // Reset during WAIT of a write to addr 7 aborts it.
        goto(50);
        a.da_en = 1; a.da_we = 1; a.da_addr = 7; a.da_wdata = 8'h99;
        tick(); a.da_en = 0; a.da_we = 0;
        rst_a = 1;
        #1;
        check_a_zero("midrst");
        goto(53);
        rst_a = 0;
        goto(55);
        chk("overrun_cleared", a.overrun, 0);
        goto(56);
        a.da_en = 1; a.da_addr = 7; push(1, 0, 8'h11, 59);
        tick(); a.da_en = 0;

        // Zero wait states: 2-cycle strobe-to-valid, one response every 2 cycles.
        goto(60);
        b.ins_en = 1; b.ins_addr = 4; push(2, 0, 8'h44, 62);
        tick(); b.ins_en = 0;
        goto(66);
        b.ins_en = 1; b.ins_addr = 4; push(2, 0, 8'h44, 68);
        tick(); b.ins_en = 0;
        tick(); b.ins_en = 1; b.ins_addr = 5; push(2, 0, 8'h55, 70);
        tick(); b.ins_en = 0;
        tick(); b.ins_en = 1; b.ins_addr = 4; push(2, 0, 8'h44, 72);
        tick(); b.ins_en = 0;

        goto(80);
        chk("a_ins_drained", qa_ins.size(), 0);
        chk("a_da_drained", qa_da.size(), 0);
        chk("b_ins_drained", qb_ins.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the accumulator CPU's controller strobes: instruction fetch (ins_en), data access (da_en, da_we).
- Serves both from one internal single-port storage array, with a configurable wait-state latency and a valid pulse per completed access.
- Arbitrates simultaneous requests and buffers one pending request per port.
- Provides a loader write port for preloading programs while the CPU is held in reset or halt.

Parameters:
- ADDR_W, 5, address width; array depth = 2**ADDR_W words.
- DATA_W, 8, word width (3-bit opcode + 5-bit operand for instructions).
- WAIT_CYCLES, 1, extra cycles between accept and response; legal 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ins_en  in  1  instruction fetch request strobe.
- ins_addr  in  ADDR_W  fetch address (PC).
- ins_data  out  DATA_W  fetched word; holds until the next fetch completes.
- ins_valid  out  1  one-cycle pulse: ins_data updated.
- da_en  in  1  data access request strobe.
- da_we  in  1  1 = write (STO), 0 = read; sampled with da_en.
- da_addr  in  ADDR_W  data address (operand field).
- da_wdata  in  DATA_W  write data (accumulator).
- da_rdata  out  DATA_W  read data; holds until the next data read completes.
- da_valid  out  1  one-cycle pulse: data read or write completed.
- stall  out  1  high while the FSM is not IDLE or any pending slot is occupied.
- ld_en  in  1  loader write strobe.
- ld_addr  in  ADDR_W  loader address.
- ld_data  in  DATA_W  loader data.
- overrun  out  1  sticky flag: a request was lost because its pending slot was full; cleared only by rst.

Behaviour:
- Reset: outputs ins_data, da_rdata, ins_valid, da_valid, stall, overrun = 0; FSM to IDLE; pending slots cleared. Array contents are not cleared by reset.
- Reset mid-operation aborts the access in flight:
  - no valid pulse;
  - an in-flight write is not committed if rst arrives before the commit edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE selects a request in priority order:
  - ld_en;
  - pending ins;
  - live ins_en;
  - pending da;
  - live da_en.
- Loader accept: array[ld_addr] <= ld_data at that edge; no response; FSM stays IDLE.
- ld_en outside IDLE, or while any slot is pending, is ignored.
- Access accept: latch address, data and we into the active registers. Next state is WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT: counter loads WAIT_CYCLES-1 at accept and decrements each cycle; go to RESP when the counter reaches 0.
- RESP, one cycle:
  - read: drive the array word to ins_data or da_rdata, pulse ins_valid or da_valid for that cycle;
  - write: commit array[addr] <= wdata at the end of RESP, pulse da_valid;
  - then return to IDLE.
- Latency: accept at edge N → valid high in the cycle after edge N+1+WAIT_CYCLES.
  - Isolated request: WAIT_CYCLES+2 cycles from strobe to valid.
- Requests arriving while not IDLE, or losing arbitration in IDLE, go to the pending slot of their port (addr, we, wdata captured).
- Slot already full on a new request for that port: new request dropped, overrun set, old pending request kept.
- ins_en and da_en in the same IDLE cycle: ins served first; da goes pending and is served immediately after (next IDLE cycle).
- Ordering within a port is strictly FIFO.
- Read after write to the same address returns the new data. The write commits in RESP before any later accept.
- Address wrap: addresses index modulo 2**ADDR_W; no out-of-range case.
- Strobes are sampled on the rising edge; a strobe held high for k cycles counts as k requests. The controller is required to pulse them for one cycle.

Test Plan:
- WAIT_CYCLES=1: ld_en writes addr 0 = 8'hA5, addr 1 = 8'h3C. ins_en with ins_addr=0 at cycle 10 → ins_valid pulses in cycle 13 with ins_data=8'hA5; stall high cycles 11–13.
- da_en, da_we=1, da_addr=5, da_wdata=8'h77 → da_valid pulse. Follow with a da read of addr 5 → da_rdata=8'h77.
- ins_en (addr 1) and da_en (read addr 0) in the same cycle → ins_valid with 8'h3C first, then da_valid with 8'hA5 exactly WAIT_CYCLES+2 cycles later; overrun stays 0.
- While busy, issue two da_en pulses (addr 2, then addr 3) → addr 2 served, addr 3 dropped, overrun=1 and sticky until rst.
- WAIT_CYCLES=0: fetch at cycle N → valid in cycle N+1 after accept edge (2-cycle strobe-to-valid); back-to-back fetches sustain one response every 2 cycles.
- rst asserted during WAIT of a write to addr 7 (old value 8'h11) → no da_valid; after release, reading addr 7 returns 8'h11. All outputs 0 during rst.
